// File: rtl/ra_clr.sv
// Two-read / one-write register array whose contents are initialised by a
// sequential clear engine. Optional macro RA_BYPASS_EN adds write-to-read forwarding.
module ra_clr #(
  parameter int              WIDTH    = 16,
  parameter int              DEPTH    = 4,
  parameter int              AW       = $clog2(DEPTH),
  parameter int              ZERO_REG = 0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    arad,
  input  logic [AW-1:0]    brad,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic [AW-1:0]    wad,
  input  logic [WIDTH-1:0] wd,
  input  logic             clr,
  output logic             busy,
  output logic             werr
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // Handshake: none. we/clr are sampled on every rising edge; a write that
  // cannot be honoured (sweep running, or clr in the same cycle) is dropped
  // and flagged on werr for exactly the following cycle.

  state_t          state, state_d;
  logic [AW-1:0]   idx, idx_d;
  logic            werr_d;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem [DEPTH];

  logic            wad_zero_blocked;
  assign wad_zero_blocked = (ZERO_REG != 0) && (wad == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      idx   <= '0;
      werr  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      werr  <= werr_d;
    end
  end

  // Next-state and the single memory write port
  always_comb begin
    state_d = state;
    idx_d   = idx;
    werr_d  = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = idx;
    mem_wd  = CLR_VAL;
    case (state)
      ST_CLEAR: begin
        mem_we = 1'b1;
        werr_d = we;
        if (clr) begin
          idx_d = '0;
        end else if (idx == LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx + AW'(1);
        end
      end
      default: begin
        if (clr) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          werr_d  = we;
        end else if (we && !wad_zero_blocked) begin
          mem_we = 1'b1;
          mem_wa = wad;
          mem_wd = wd;
        end
      end
    endcase
  end

  // No reset on the storage so it stays RAM-inferable; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  logic fwd_ok;
  assign fwd_ok = (state == ST_IDLE) && !rst && we && !clr && !wad_zero_blocked;

  // Outputs
  always_comb begin
    busy = (state == ST_CLEAR);
    a    = '0;
    b    = '0;
    if (!busy) begin
      if (!((ZERO_REG != 0) && (arad == '0))) a = mem[arad];
      if (!((ZERO_REG != 0) && (brad == '0))) b = mem[brad];
`ifdef RA_BYPASS_EN
      if (fwd_ok && (wad == arad)) a = wd;
      if (fwd_ok && (wad == brad)) b = wd;
`endif
    end
  end

`ifndef RA_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = fwd_ok;
`endif

endmodule
